rv_divider: RTL and testbench

- Parametrised iterative integer divider for the rv64 core's long-latency execute pipe.
- Implements the full RISC-V M divide group: DIV, DIVU, REM, REMU and the word forms DIVW, DIVUW, REMW, REMUW.
- Retires a configurable number of quotient bits per cycle and handles divide-by-zero and signed overflow architecturally.
- Adds a flush input for pipeline kills and a valid/ready writeback handshake with backpressure.

---
 rtl/rv_divider.sv | 231 +++++++++++++++++++++++
 tb/tb_rv_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_divider.sv
// rv_divider: iterative restoring integer divider for the rv64 long-latency
// execute pipe. Covers DIV/DIVU/REM/REMU and their 32-bit W forms, resolves
// BITS_PER_ITER quotient bits per cycle, short-circuits divide-by-zero and
// signed overflow, supports pipeline flush and a valid/ready writeback.

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

module rv_divider #(
    parameter int LG_W          = 6,
    parameter int BITS_PER_ITER = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          start_div,
    input  logic [(1<<LG_W)-1:0]          srcA,
    input  logic [(1<<LG_W)-1:0]          srcB,
    input  logic                          is_signed,
    input  logic                          is_rem,
    input  logic                          is_word,
    input  logic [`LG_ROB_ENTRIES-1:0]    rob_ptr_in,
    input  logic [`LG_PRF_ENTRIES-1:0]    prf_ptr_in,
    output logic                          ready,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [(1<<LG_W)-1:0]          y,
    output logic [`LG_ROB_ENTRIES-1:0]    rob_ptr_out,
    output logic [`LG_PRF_ENTRIES-1:0]    prf_ptr_out
);
    localparam int W  = 1 << LG_W;
    localparam int CW = LG_W + 1;
    localparam logic [CW-1:0] ITER_FULL = CW'(W / BITS_PER_ITER - 1);
    localparam logic [CW-1:0] ITER_WORD = CW'(32 / BITS_PER_ITER - 1);

    // Word forms need a datapath wider than 32 bits; step count must divide 32.
    if (!(BITS_PER_ITER == 1 || BITS_PER_ITER == 2 || BITS_PER_ITER == 4) || LG_W < 6) begin : g_bad_param
        $error("rv_divider: illegal LG_W or BITS_PER_ITER");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INPUT_SIGN,
        S_DIVIDE,
        S_OUTPUT_SIGN,
        S_DONE
    } state_t;

    state_t                       state_q;
    logic [W-1:0]                 a_q;
    logic [W-1:0]                 b_q;
    logic [W:0]                   rem_q;
    logic [W-1:0]                 quo_q;
    logic [CW-1:0]                cnt_q;
    logic                         is_signed_q;
    logic                         is_rem_q;
    logic                         is_word_q;
    logic                         qsign_q;
    logic                         rsign_q;
    logic                         y_valid_q;
    logic [W-1:0]                 y_q;
    logic [`LG_ROB_ENTRIES-1:0]   rob_q;
    logic [`LG_PRF_ENTRIES-1:0]   prf_q;

    // Extend a 32-bit value to the datapath width.
    function automatic logic [W-1:0] ext32(input logic [31:0] v, input logic sgn);
        return {{(W-32){sgn & v[31]}}, v};
    endfunction

    // Two's-complement negate when enabled.
    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    // Operand preparation: width extension, sign capture, magnitudes, special cases.
    logic [W-1:0] opa_d;
    logic [W-1:0] opb_d;
    logic [W-1:0] most_neg_d;
    logic [W-1:0] mag_a_d;
    logic [W-1:0] mag_b_d;
    logic [W-1:0] spec_sel_d;
    logic [W-1:0] special_y_d;
    logic [W-1:0] quo_init_d;
    logic         div_zero_d;
    logic         ovf_d;
    logic         qsign_d;
    logic         rsign_d;

    always_comb begin
        opa_d       = is_word_q ? ext32(a_q[31:0], is_signed_q) : a_q;
        opb_d       = is_word_q ? ext32(b_q[31:0], is_signed_q) : b_q;
        most_neg_d  = is_word_q ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
        div_zero_d  = (opb_d == '0);
        ovf_d       = is_signed_q && (opa_d == most_neg_d) && (opb_d == '1);
        qsign_d     = is_signed_q & (opa_d[W-1] ^ opb_d[W-1]);
        rsign_d     = is_signed_q & opa_d[W-1];
        mag_a_d     = cond_neg(opa_d, rsign_d);
        mag_b_d     = cond_neg(opb_d, is_signed_q & opb_d[W-1]);
        if (div_zero_d) begin
            spec_sel_d = is_rem_q ? opa_d : {W{1'b1}};
        end else begin
            spec_sel_d = is_rem_q ? {W{1'b0}} : opa_d;
        end
        special_y_d = is_word_q ? ext32(spec_sel_d[31:0], 1'b1) : spec_sel_d;
        // Word dividends are left-aligned so 32 steps consume exactly their bits.
        quo_init_d  = is_word_q ? {mag_a_d[31:0], {(W-32){1'b0}}} : mag_a_d;
    end

    // One DIVIDE cycle: BITS_PER_ITER chained restoring shift/compare/subtract steps.
    logic [W:0]   rem_d;
    logic [W-1:0] quo_d;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        for (int i = 0; i < BITS_PER_ITER; i++) begin
            rem_d = {rem_d[W-1:0], quo_d[W-1]};
            quo_d = {quo_d[W-2:0], 1'b0};
            if (rem_d >= {1'b0, b_q}) begin
                rem_d    = rem_d - {1'b0, b_q};
                quo_d[0] = 1'b1;
            end
        end
    end

    // Final sign fix-up, quotient/remainder select and word sign-extension.
    logic [W-1:0] q_fix_d;
    logic [W-1:0] r_fix_d;
    logic [W-1:0] res_sel_d;
    logic [W-1:0] result_d;

    always_comb begin
        q_fix_d   = cond_neg(quo_q, qsign_q);
        r_fix_d   = cond_neg(rem_q[W-1:0], rsign_q);
        res_sel_d = is_rem_q ? r_fix_d : q_fix_d;
        result_d  = is_word_q ? ext32(res_sel_d[31:0], 1'b1) : res_sel_d;
    end

    // The remainder top bit only guards the compare; a settled remainder never sets it.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[W];

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            is_word_q   <= 1'b0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            y_valid_q   <= 1'b0;
            y_q         <= '0;
            rob_q       <= '0;
            prf_q       <= '0;
        end else if (flush) begin
            state_q   <= S_IDLE;
            y_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_div) begin
                        a_q         <= srcA;
                        b_q         <= srcB;
                        is_signed_q <= is_signed;
                        is_rem_q    <= is_rem;
                        is_word_q   <= is_word;
                        rob_q       <= rob_ptr_in;
                        prf_q       <= prf_ptr_in;
                        state_q     <= S_INPUT_SIGN;
                    end
                end
                S_INPUT_SIGN: begin
                    if (div_zero_d || ovf_d) begin
                        y_q       <= special_y_d;
                        y_valid_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        b_q     <= mag_b_d;
                        quo_q   <= quo_init_d;
                        rem_q   <= '0;
                        qsign_q <= qsign_d;
                        rsign_q <= rsign_d;
                        cnt_q   <= is_word_q ? ITER_WORD : ITER_FULL;
                        state_q <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q <= S_OUTPUT_SIGN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_OUTPUT_SIGN: begin
                    y_q       <= result_d;
                    y_valid_q <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign y_valid     = y_valid_q;
    assign y           = y_q;
    assign rob_ptr_out = rob_q;
    assign prf_ptr_out = prf_q;

endmodule

// File: tb/tb_rv_divider.sv
// tb_rv_divider: directed and randomized checks of rv_divider against a
// plain-arithmetic RISC-V division reference model.

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif

module tb_rv_divider;
    localparam int W    = 64;
    localparam int BPI  = 2;
    localparam int ROBW = `LG_ROB_ENTRIES;
    localparam int PRFW = `LG_PRF_ENTRIES;

    logic            clk = 1'b0;
    logic            reset, flush, start_div, is_signed, is_rem, is_word, y_ready;
    logic [W-1:0]    srcA, srcB, y;
    logic            ready, y_valid;
    logic [ROBW-1:0] rob_ptr_in, rob_ptr_out;
    logic [PRFW-1:0] prf_ptr_in, prf_ptr_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_divider #(.LG_W(6), .BITS_PER_ITER(BPI)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start_div(start_div),
        .srcA(srcA), .srcB(srcB), .is_signed(is_signed), .is_rem(is_rem),
        .is_word(is_word), .rob_ptr_in(rob_ptr_in), .prf_ptr_in(prf_ptr_in),
        .ready(ready), .y_valid(y_valid), .y_ready(y_ready), .y(y),
        .rob_ptr_out(rob_ptr_out), .prf_ptr_out(prf_ptr_out)
    );

    // RISC-V M-extension result, computed with native arithmetic.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input bit sg, input bit rm, input bit wd);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (wd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)                                         r32 = rm ? a32 : 32'hFFFF_FFFF;
            else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rm ? 32'd0 : a32;
            else if (sg)                                              r32 = rm ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else                                                      r32 = rm ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                                 r64 = rm ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = rm ? 64'd0 : a;
        else if (sg)                                                    r64 = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else                                                            r64 = rm ? a % b : a / b;
        return r64;
    endfunction

    // Cycles from the accept edge to the first y_valid cycle.
    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input bit sg, input bit wd);
        if (wd) begin
            if (b[31:0] == 32'd0 || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 2;
            return 32 / BPI + 3;
        end
        if (b == 64'd0 || (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)) return 2;
        return W / BPI + 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency/result/tags, optionally stall writeback, then retire.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit sg, input bit rm, input bit wd, input int hold,
                          output logic [63:0] y_obs);
        logic [63:0]     exp;
        int              lat, cyc;
        logic [ROBW-1:0] rob;
        logic [PRFW-1:0] prf;
        exp = ref_div(a, b, sg, rm, wd);
        lat = ref_lat(a, b, sg, wd);
        rob = ROBW'($urandom);
        prf = PRFW'($urandom);
        @(negedge clk);
        chk({tag, " ready_idle"}, 64'(ready), 64'd1);
        start_div = 1'b1; srcA = a; srcB = b; is_signed = sg; is_rem = rm; is_word = wd;
        rob_ptr_in = rob; prf_ptr_in = prf;
        @(negedge clk);
        start_div = 1'b0; srcA = {$urandom, $urandom}; srcB = {$urandom, $urandom};
        rob_ptr_in = ROBW'($urandom); prf_ptr_in = PRFW'($urandom);
        cyc = 1;
        while (!y_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        y_obs = y;
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " y"}, y, exp);
        chk({tag, " rob"}, 64'(rob_ptr_out), 64'(rob));
        chk({tag, " prf"}, 64'(prf_ptr_out), 64'(prf));
        chk({tag, " busy"}, 64'(ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            start_div = 1'b1;
            @(negedge clk);
            chk({tag, " hold_valid"}, 64'(y_valid), 64'd1);
            chk({tag, " hold_y"}, y, exp);
            chk({tag, " hold_rob"}, 64'(rob_ptr_out), 64'(rob));
            chk({tag, " hold_ready"}, 64'(ready), 64'd0);
        end
        start_div = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        chk({tag, " retire_valid"}, 64'(y_valid), 64'd0);
        chk({tag, " retire_ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    logic [63:0] ra, rb, yo;
    bit          rsg, rrm, rwd, seen;

    initial begin
        reset = 1'b1; flush = 1'b0; start_div = 1'b0; y_ready = 1'b0;
        srcA = '0; srcB = '0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        rob_ptr_in = '0; prf_ptr_in = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset y_valid", 64'(y_valid), 64'd0);
        chk("reset y", y, 64'd0);
        chk("reset rob", 64'(rob_ptr_out), 64'd0);
        chk("reset prf", 64'(prf_ptr_out), 64'd0);
        reset = 1'b0;

        // Directed cases with hand-computed results.
        run_op("divu100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 10, yo);
        chk("divu100_7 const", yo, 64'd14);
        run_op("remu100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 0, yo);
        chk("remu100_7 const", yo, 64'd2);
        run_op("div-7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 0, yo);
        chk("div-7_2 const", yo, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem-7_2", -64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 0, yo);
        chk("rem-7_2 const", yo, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem7_-2", 64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 0, yo);
        chk("rem7_-2 const", yo, 64'd1);
        run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 0, yo);
        chk("div_ovf const", yo, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 0, yo);
        chk("rem_ovf const", yo, 64'd0);
        run_op("divu_by0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 0, yo);
        chk("divu_by0 const", yo, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_by0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 0, yo);
        chk("remu_by0 const", yo, 64'd5);
        run_op("divuw", 64'hFFFF_FFFF_0000_0010, 64'd2, 1'b0, 1'b0, 1'b1, 0, yo);
        chk("divuw const", yo, 64'd8);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 0, yo);
        chk("divw_ovf const", yo, 64'hFFFF_FFFF_8000_0000);
        run_op("remuw_by0", 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b1, 2, yo);
        chk("remuw_by0 const", yo, 64'hFFFF_FFFF_9ABC_DEF0);

        // Flush in the fifth DIVIDE cycle kills the op.
        @(negedge clk);
        start_div = 1'b1; srcA = 64'hFFFF_FFFF_FFFF_FFFF; srcB = 64'd3;
        is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        @(negedge clk);
        start_div = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush ready", 64'(ready), 64'd1);
        chk("flush y_valid", 64'(y_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (y_valid) seen = 1'b1;
        end
        chk("flush no_result", 64'(seen), 64'd0);
        run_op("divu9_3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 0, yo);
        chk("divu9_3 const", yo, 64'd3);

        // Start coinciding with flush is dropped.
        @(negedge clk);
        start_div = 1'b1; flush = 1'b1; srcA = 64'd5; srcB = 64'd0;
        @(negedge clk);
        start_div = 1'b0; flush = 1'b0;
        chk("flush_start ready", 64'(ready), 64'd1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (y_valid) seen = 1'b1;
        end
        chk("flush_start no_result", 64'(seen), 64'd0);

        // Flush in DONE together with y_ready.
        start_div = 1'b1; srcA = 64'd5; srcB = 64'd0; is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0;
        @(negedge clk);
        start_div = 1'b0;
        @(negedge clk);
        chk("done_flush pre_valid", 64'(y_valid), 64'd1);
        flush = 1'b1; y_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; y_ready = 1'b0;
        chk("done_flush valid", 64'(y_valid), 64'd0);
        chk("done_flush ready", 64'(ready), 64'd1);

        // Reset in the middle of an op.
        start_div = 1'b1; srcA = 64'd1000; srcB = 64'd7; rob_ptr_in = '1; prf_ptr_in = '1;
        @(negedge clk);
        start_div = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset ready", 64'(ready), 64'd1);
        chk("midreset y_valid", 64'(y_valid), 64'd0);
        chk("midreset y", y, 64'd0);
        chk("midreset rob", 64'(rob_ptr_out), 64'd0);
        chk("midreset prf", 64'(prf_ptr_out), 64'd0);

        // Randomized ops biased toward the interesting corners.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: rb = 64'($urandom_range(0, 3));
                1: rb = 64'd0;
                2: begin ra = 64'h8000_0000_0000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
                3: begin ra = {$urandom, 32'h8000_0000}; rb = {$urandom, 32'hFFFF_FFFF}; end
                4: ra = ra >> $urandom_range(0, 63);
                5: rb = rb >> $urandom_range(0, 63);
                default: ;
            endcase
            rsg = 1'($urandom);
            rrm = 1'($urandom);
            rwd = 1'($urandom);
            run_op("rand", ra, rb, rsg, rrm, rwd, $urandom_range(0, 2), yo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
